stack_master: RTL and testbench
===============================

STACK_MASTER -- requirements
Module: stack_master

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 24, instruction word width.
- DEPTH, 256, stack capacity in entries.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  operation request.
- req_ready  out  1  request accepted when high together with req_valid.
- req_op  in  1  0 = push, 1 = pop.
- req_data  in  WIDTH  push data.
- rsp_valid  out  1  pop data available.
- rsp_ready  in  1  pop data consumed.
- rsp_data  out  WIDTH  popped word.
- err  out  1  one-cycle pulse on a rejected op.
- depth  out  9  current occupancy, 0..DEPTH.
- full  out  1  depth == DEPTH.
- empty  out  1  depth == 0.
- stk_push  out  1  push command to the stack.
- stk_pop  out  1  pop command to the stack.
- stk_in  out  WIDTH  push data to the stack.
- stk_out  in  WIDTH  read data from the stack.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE, P_CMD, P_W0, P_W1, Q_CMD, Q_W0, Q_W1, Q_CAP and RESP.
REQ-005 req_ready SHALL be 1 only in IDLE.
REQ-006 A handshake with req_op=0 and full=0 SHALL go IDLE->P_CMD->P_W0->P_W1->IDLE, one state per cycle.
REQ-007 A handshake with req_op=1 and empty=0 SHALL go IDLE->Q_CMD->Q_W0->Q_W1->Q_CAP->RESP.
REQ-008 stk_push SHALL be 1 only in P_CMD, and stk_pop 1 only in Q_CMD; each is exactly a one-cycle pulse, and the two are never both high.
REQ-009 stk_in SHALL be registered from req_data at the push handshake and held unchanged through P_W1 and until the next accepted push.
REQ-010 In Q_CAP the block SHALL register stk_out into rsp_data.
REQ-011 rsp_valid SHALL be 1 exactly in RESP, with rsp_data stable; RESP->IDLE SHALL occur on the cycle rsp_ready=1, and RESP SHALL hold otherwise.
REQ-012 depth SHALL increment on the P_CMD edge and decrement on the Q_CMD edge, never wrapping.
REQ-013 A push with full=1, or a pop with empty=1, SHALL still be handshaken, SHALL issue no stk command and change no depth, SHALL pulse err for the cycle after the handshake, and SHALL keep the FSM in IDLE.
REQ-014 Throughput SHALL be at most one push per 4 cycles and one pop per 6 cycles including the response handshake; back-to-back requests with no idle cycles between them SHALL be legal.
REQ-015 full and empty SHALL be combinational decodes of the registered depth.
REQ-016 err SHALL be 0 in every cycle not covered by REQ-013.

Reset
REQ-017 On reset assertion the block SHALL go to IDLE immediately, asynchronously.
REQ-018 Reset values SHALL be: depth=0, empty=1, full=0, stk_push=0, stk_pop=0, stk_in=0, rsp_valid=0, rsp_data=0, err=0.
REQ-019 A reset asserted mid-operation SHALL abandon the operation with no response.
REQ-020 The integrator SHALL reset the stack in the same cycles, because this block does not drive the stack's reset.
REQ-021 req_ready SHALL be 1 in the first clock cycle after reset deasserts.

Structure
REQ-022 Package stack_pkg SHALL hold WIDTH, DEPTH, the OP_PUSH/OP_POP encodings and the FSM state typedef; the stack and stack_master SHALL share them.
REQ-023 The occupancy logic SHALL be one sub-module, stack_depth_counter, providing inc, dec, depth, full and empty.

Verification
REQ-024 Push 24'hABCDEF from reset:
- stk_push pulses 1 cycle after the handshake.
- stk_in = 24'hABCDEF is stable for 3 cycles.
- depth = 1.
- req_ready returns high 4 cycles after the handshake.
REQ-025 Push 24'h000011, then pop with rsp_ready held low for 5 cycles:
- rsp_valid rises 5 cycles after the pop handshake.
- rsp_valid holds with rsp_data equal to the stk_out value at Q_CAP.
- depth returns to 0 after the pop.
REQ-026 Pop at depth=0: err pulses exactly 1 cycle, stk_pop stays 0, depth stays 0.
REQ-027 256 pushes, then a 257th:
- full = 1 after the 256th push.
- the 257th push gives an err pulse, no stk_push and depth = 256.
REQ-028 Assert reset during Q_W0: outputs take their reset values within the same cycle, and no rsp_valid appears afterwards.
REQ-029 Alternate push and pop 100 times with random rsp_ready:
- stk_push and stk_pop are never both high.
- depth matches a reference model every cycle.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared constants, request encoding and controller state type for the stack
// master and the stack it drives.
package stack_pkg;

    localparam int WIDTH   = 24;
    localparam int DEPTH   = 256;
    localparam int DEPTH_W = $clog2(DEPTH + 1);

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } op_e;

    typedef enum logic [3:0] {
        IDLE,
        P_CMD,
        P_W0,
        P_W1,
        Q_CMD,
        Q_W0,
        Q_W1,
        Q_CAP,
        RESP
    } state_e;

endpackage

// File: rtl/stack_depth_counter.sv
// Saturating occupancy counter for the external stack; full and empty are
// decoded straight from the registered count.
module stack_depth_counter
    import stack_pkg::*;
#(
    parameter int DEPTH = stack_pkg::DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         inc,
    input  logic                         dec,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] depth_q;
    logic [CW-1:0] depth_d;

    assign full  = (depth_q == CW'(DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;

    always_comb begin
        depth_d = depth_q;
        if (inc && !dec && !full) begin
            depth_d = depth_q + CW'(1);
        end else if (dec && !inc && !empty) begin
            depth_d = depth_q - CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/stack_master.sv
// Request/response front end that sequences single push and pop commands onto
// an external stack with fixed wait states and tracks its occupancy.
module stack_master
    import stack_pkg::*;
#(
    parameter int WIDTH = stack_pkg::WIDTH,
    parameter int DEPTH = stack_pkg::DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_op,
    input  logic [WIDTH-1:0]             req_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [WIDTH-1:0]             rsp_data,
    output logic                         err,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty,
    output logic                         stk_push,
    output logic                         stk_pop,
    output logic [WIDTH-1:0]             stk_in,
    input  logic [WIDTH-1:0]             stk_out
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   stk_in_q, stk_in_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               err_q, err_d;

    stack_depth_counter #(
        .DEPTH (DEPTH)
    ) u_depth (
        .clk   (clk),
        .reset (reset),
        .inc   (stk_push),
        .dec   (stk_pop),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    // NOTE: every output of this block gets a default before the case, so no
    // path through it can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        stk_in_d   = stk_in_q;
        rsp_data_d = rsp_data_q;
        err_d      = 1'b0;
        req_ready  = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        rsp_valid  = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    // Rejected ops are still accepted, flagged, and leave us in IDLE.
                    if (op_e'(req_op) == OP_PUSH) begin
                        if (!full) begin
                            state_d  = P_CMD;
                            stk_in_d = req_data;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        if (!empty) begin
                            state_d = Q_CMD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            P_CMD: begin
                stk_push = 1'b1;
                state_d  = P_W0;
            end
            P_W0:  state_d = P_W1;
            P_W1:  state_d = IDLE;
            Q_CMD: begin
                stk_pop = 1'b1;
                state_d = Q_W0;
            end
            Q_W0:  state_d = Q_W1;
            Q_W1:  state_d = Q_CAP;
            Q_CAP: begin
                rsp_data_d = stk_out;
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            stk_in_q   <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stk_in_q   <= stk_in_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
        end
    end

    assign stk_in   = stk_in_q;
    assign rsp_data = rsp_data_q;
    assign err      = err_q;

endmodule

// File: tb/tb_stack_master.sv
// Self-checking bench for stack_master: table of single ops, fill-to-full,
// reset mid-pop and a random push/pop run, with a behavioural stack attached.
module tb_stack_master;
    import stack_pkg::*;

    localparam int W = 24;
    localparam int D = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_op = 1'b0;
    logic [W-1:0]  req_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_data;
    logic          err;
    logic [8:0]    depth;
    logic          full;
    logic          empty;
    logic          stk_push;
    logic          stk_pop;
    logic [W-1:0]  stk_in;
    logic [W-1:0]  stk_out;

    int n_cmp  = 0;
    int n_fail = 0;

    int            model_depth = 0;
    logic          exp_err = 1'b0;
    logic [W-1:0]  sb_q[$];
    logic [W-1:0]  ref_stack[$];

    always #5 clk = ~clk;

    stack_master #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .err       (err),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_in    (stk_in),
        .stk_out   (stk_out)
    );

    // Behavioural stack: registered read data appears the cycle after the pop.
    logic [W-1:0] mem [D];
    int           sp;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sp      <= 0;
            stk_out <= '0;
        end else if (stk_push && sp < D) begin
            mem[sp] <= stk_in;
            sp      <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            stk_out <= mem[sp-1];
            sp      <= sp - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("depth_model", 32'(depth), 32'(model_depth));
            check("full_decode", 32'(full), 32'(model_depth == D));
            check("empty_decode", 32'(empty), 32'(model_depth == 0));
            check("push_pop_excl", 32'(stk_push && stk_pop), 32'd0);
            check("err_cycle", 32'(err), 32'(exp_err));
        end
    end

    // Caller must be sitting just after a falling edge.
    task automatic do_op(input logic op, input logic [W-1:0] data, input int delay,
                         input logic exp_rej, input logic [W-1:0] exp_rsp);
        bit got = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_err = exp_rej;
        if (!exp_rej && op == OP_POP) sb_q.push_back(exp_rsp);
        @(negedge clk);
        req_valid = 1'b0;
        if (exp_rej) begin
            check("rej_err", 32'(err), 32'd1);
            check("rej_push", 32'(stk_push), 32'd0);
            check("rej_pop", 32'(stk_pop), 32'd0);
            check("rej_ready", 32'(req_ready), 32'd1);
            @(posedge clk);
            exp_err = 1'b0;
            @(negedge clk);
            check("rej_err_drop", 32'(err), 32'd0);
            return;
        end
        if (op == OP_PUSH) begin
            check("push_pulse", 32'(stk_push), 32'd1);
            check("push_no_pop", 32'(stk_pop), 32'd0);
            check("push_stk_in", 32'(stk_in), 32'(data));
        end else begin
            check("pop_pulse", 32'(stk_pop), 32'd1);
            check("pop_no_push", 32'(stk_push), 32'd0);
        end
        check("busy_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        exp_err = 1'b0;
        if (op == OP_PUSH) begin
            model_depth++;
            ref_stack.push_back(data);
        end else begin
            model_depth--;
            void'(ref_stack.pop_back());
        end
        if (op == OP_PUSH) begin
            for (int k = 2; k <= 4; k++) begin
                @(negedge clk);
                check("push_pulse_end", 32'(stk_push), 32'd0);
                check("push_stk_in_hold", 32'(stk_in), 32'(data));
                check("push_ready", 32'(req_ready), 32'(k == 4));
            end
        end else begin
            for (int k = 2; k <= 4; k++) begin
                @(negedge clk);
                check("pop_pulse_end", 32'(stk_pop), 32'd0);
                check("pop_early_valid", 32'(rsp_valid), 32'd0);
                check("pop_ready", 32'(req_ready), 32'd0);
            end
            @(negedge clk);
            for (int d = 0; d <= delay; d++) begin
                check("rsp_valid", 32'(rsp_valid), 32'd1);
                check("rsp_data", 32'(rsp_data), 32'(sb_q[0]));
                if (d < delay) @(negedge clk);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            void'(sb_q.pop_front());
            check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
            check("rsp_back_idle", 32'(req_ready), 32'd1);
        end
    endtask

    typedef struct {
        logic          op;
        logic [W-1:0]  data;
        int            delay;
        logic          exp_rej;
        logic [W-1:0]  exp_rsp;
        int            exp_depth;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #100ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] d;
        bit           rej;

        vecs[0]  = '{OP_POP,  24'h000000, 0, 1'b1, 24'h000000, 0};
        vecs[1]  = '{OP_PUSH, 24'hABCDEF, 0, 1'b0, 24'h000000, 1};
        vecs[2]  = '{OP_POP,  24'h000000, 0, 1'b0, 24'hABCDEF, 0};
        vecs[3]  = '{OP_PUSH, 24'h000011, 0, 1'b0, 24'h000000, 1};
        vecs[4]  = '{OP_POP,  24'h000000, 5, 1'b0, 24'h000011, 0};
        vecs[5]  = '{OP_POP,  24'h000000, 0, 1'b1, 24'h000000, 0};
        vecs[6]  = '{OP_PUSH, 24'h5A5A5A, 0, 1'b0, 24'h000000, 1};
        vecs[7]  = '{OP_PUSH, 24'hA5A5A5, 0, 1'b0, 24'h000000, 2};
        vecs[8]  = '{OP_POP,  24'h000000, 2, 1'b0, 24'hA5A5A5, 1};
        vecs[9]  = '{OP_PUSH, 24'hFFFFFF, 0, 1'b0, 24'h000000, 2};
        vecs[10] = '{OP_POP,  24'h000000, 1, 1'b0, 24'hFFFFFF, 1};
        vecs[11] = '{OP_POP,  24'h000000, 0, 1'b0, 24'h5A5A5A, 0};

        #1;
        check("rst_depth", 32'(depth), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_stk_in", 32'(stk_in), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check("ready_after_reset", 32'(req_ready), 32'd1);
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].op, vecs[i].data, vecs[i].delay, vecs[i].exp_rej, vecs[i].exp_rsp);
            check($sformatf("vec%0d_depth", i), 32'(depth), 32'(vecs[i].exp_depth));
        end

        for (int i = 0; i < D; i++) begin
            do_op(OP_PUSH, W'(i * 3 + 1), 0, 1'b0, '0);
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_depth", 32'(depth), 32'(D));
        do_op(OP_PUSH, 24'h777777, 0, 1'b1, '0);
        check("over_depth", 32'(depth), 32'(D));
        check("over_full", 32'(full), 32'd1);
        for (int i = 0; i < 2; i++) begin
            do_op(OP_POP, '0, i, 1'b0, ref_stack[$]);
        end
        check("drain_depth", 32'(depth), 32'(D - 2));

        // Reset during Q_W0 of an accepted pop.
        req_valid = 1'b1;
        req_op    = OP_POP;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        model_depth--;
        @(negedge clk);
        #2 reset = 1'b1;
        model_depth = 0;
        exp_err     = 1'b0;
        sb_q.delete();
        ref_stack.delete();
        #1;
        check("mid_rst_depth", 32'(depth), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_full", 32'(full), 32'd0);
        check("mid_rst_push", 32'(stk_push), 32'd0);
        check("mid_rst_pop", 32'(stk_pop), 32'd0);
        check("mid_rst_stk_in", 32'(stk_in), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check("mid_rst_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abandoned_rsp", 32'(rsp_valid), 32'd0);
        end

        for (int i = 0; i < 100; i++) begin
            d   = W'($urandom);
            rej = (model_depth >= D);
            do_op(OP_PUSH, d, 0, rej, '0);
            rej = (model_depth == 0);
            do_op(OP_POP, '0, int'($urandom_range(0, 3)), rej, rej ? '0 : ref_stack[$]);
        end
        check("final_depth", 32'(depth), 32'(model_depth));
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
